// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing NUM_REGS x DATA_W control registers with read-back.
// Writes commit atomically on the nCS rise; malformed frames are dropped and flagged.
module spi_reg_bank #(
    parameter int                SYNC_FLOPS = 2,
    parameter int                NUM_REGS   = 8,
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 7,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);

    logic [SYNC_FLOPS-1:0]        sclk_sync_q, sclk_sync_d;
    logic [SYNC_FLOPS-1:0]        copi_sync_q, copi_sync_d;
    logic [SYNC_FLOPS-1:0]        ncs_sync_q, ncs_sync_d;
    logic                         sclk_prev_q, sclk_prev_d;
    logic                         ncs_prev_q, ncs_prev_d;
    logic                         active_q, active_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [FRAME_W-1:0]           rx_q, rx_d;
    logic [DATA_W-1:0]            rd_q, rd_d;
    logic [NUM_REGS*DATA_W-1:0]   regs_q, regs_d;
    logic                         wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
    logic                         frame_err_q, frame_err_d;
    logic                         cipo_q, cipo_d;

    logic                         sclk_s, copi_s, ncs_s;
    logic                         sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic [FRAME_W-1:0]           rx_shift;
    logic                         fr_rw;
    logic [ADDR_W-1:0]            fr_addr;
    logic [DATA_W-1:0]            fr_data;

    function automatic logic [DATA_W-1:0] reg_lookup(
        input logic [NUM_REGS*DATA_W-1:0] r,
        input logic [ADDR_W-1:0]          a
    );
        logic [DATA_W-1:0] val;
        val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) val = r[i*DATA_W +: DATA_W];
        end
        return val;
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_FLOPS-2:0], SCLK};
        copi_sync_d = {copi_sync_q[SYNC_FLOPS-2:0], COPI};
        ncs_sync_d  = {ncs_sync_q[SYNC_FLOPS-2:0], nCS};
        sclk_s      = sclk_sync_q[SYNC_FLOPS-1];
        copi_s      = copi_sync_q[SYNC_FLOPS-1];
        ncs_s       = ncs_sync_q[SYNC_FLOPS-1];
        sclk_prev_d = sclk_s;
        ncs_prev_d  = ncs_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        ncs_rise    = ncs_s & ~ncs_prev_q;
        ncs_fall    = ~ncs_s & ncs_prev_q;
        rx_shift    = {rx_q[FRAME_W-2:0], copi_s};
        fr_rw       = rx_q[FRAME_W-1];
        fr_addr     = rx_q[FRAME_W-2 -: ADDR_W];
        fr_data     = rx_q[DATA_W-1:0];
    end

    always_comb begin
        active_d    = active_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        rd_d        = rd_q;
        regs_d      = regs_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        if (ncs_fall) begin
            active_d = 1'b1;
            cnt_d    = '0;
            rx_d     = '0;
            rd_d     = '0;
        end else if (ncs_rise) begin
            if (active_q) begin
                active_d = 1'b0;
                rd_d     = '0;
                // A frame is valid only with the exact bit count; extra bits count as malformed.
                if (cnt_q != CNT_FRAME) begin
                    frame_err_d = 1'b1;
                end else if (fr_rw && addr_in_range(fr_addr)) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (fr_addr == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = fr_data;
                    end
                    wr_pulse_d = 1'b1;
                    wr_addr_d  = fr_addr;
                end
            end
        end else if (active_q) begin
            if (sclk_rise) begin
                rx_d = rx_shift;
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_PRE && !rx_shift[ADDR_W]) begin
                    rd_d = reg_lookup(regs_q, rx_shift[ADDR_W-1:0]);
                end
            end else if (sclk_fall && cnt_q > CNT_ADDR) begin
                // The fall right after the address completes keeps the MSB for the next rise.
                rd_d = rd_q << 1;
            end
        end
        cipo_d = active_q & rd_q[DATA_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            active_q    <= 1'b0;
            cnt_q       <= '0;
            rx_q        <= '0;
            rd_q        <= '0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            cipo_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            rd_q        <= rd_d;
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            cipo_q      <= cipo_d;
        end
    end

    assign CIPO      = cipo_q;
    assign cipo_oe   = active_q;
    assign regs_flat = regs_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: default configuration (A) and a 4x16-bit,
// 3-bit-address configuration with a non-zero reset value (B).
module tb_spi_reg_bank;
    localparam int H = 6;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sclk_v, copi_v, ncs_v;

    logic        cipo_a, oe_a, wp_a, fe_a;
    logic [63:0] regs_a;
    logic [6:0]  wa_a;
    logic        cipo_b, oe_b, wp_b, fe_b;
    logic [63:0] regs_b;
    logic [2:0]  wa_b;

    int total;
    int bad;

    spi_reg_bank dut_a (
        .clk(clk), .rst_n(rst_n),
        .SCLK(sclk_v[0]), .COPI(copi_v[0]), .nCS(ncs_v[0]),
        .CIPO(cipo_a), .cipo_oe(oe_a), .regs_flat(regs_a),
        .wr_pulse(wp_a), .wr_addr(wa_a), .frame_err(fe_a)
    );

    spi_reg_bank #(
        .SYNC_FLOPS(2), .NUM_REGS(4), .DATA_W(16), .ADDR_W(3), .RESET_VAL(16'h5A5A)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .SCLK(sclk_v[1]), .COPI(copi_v[1]), .nCS(ncs_v[1]),
        .CIPO(cipo_b), .cipo_oe(oe_b), .regs_flat(regs_b),
        .wr_pulse(wp_b), .wr_addr(wa_b), .frame_err(fe_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low(input int d);
        ncs_v[d] = 1'b0;
        tick(H);
    endtask

    task automatic spi_bits(input int d, input int n, input logic [31:0] bits,
                            output logic [31:0] miso, output logic oe_seen);
        miso = '0;
        oe_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            copi_v[d] = bits[n-1-i];
            tick(H);
            miso = {miso[30:0], (d == 0) ? cipo_a : cipo_b};
            oe_seen = (d == 0) ? oe_a : oe_b;
            sclk_v[d] = 1'b1;
            tick(H);
            sclk_v[d] = 1'b0;
        end
        copi_v[d] = 1'b0;
    endtask

    task automatic cs_high_watch(input int d, output logic [5:0] wp_h, output logic [5:0] fe_h);
        tick(H);
        ncs_v[d] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            wp_h[k] = (d == 0) ? wp_a : wp_b;
            fe_h[k] = (d == 0) ? fe_a : fe_b;
        end
        tick(H);
    endtask

    task automatic do_frame(input int d, input int n, input logic [31:0] bits,
                            output logic [31:0] miso, output logic oe_seen,
                            output logic [5:0] wp_h, output logic [5:0] fe_h);
        cs_low(d);
        spi_bits(d, n, bits, miso, oe_seen);
        cs_high_watch(d, wp_h, fe_h);
    endtask

    initial begin
        logic [31:0] miso;
        logic        oe;
        logic [5:0]  wph, feh;
        total = 0;
        bad   = 0;
        rst_n  = 1'b0;
        sclk_v = 2'b00;
        copi_v = 2'b00;
        ncs_v  = 2'b11;
        tick(3);

        chk("rst_regs_a", regs_a, 64'h0);
        chk("rst_regs_b", regs_b, 64'h5A5A_5A5A_5A5A_5A5A);
        chk("rst_cipo_a", {63'b0, cipo_a}, 64'h0);
        chk("rst_oe_a", {63'b0, oe_a}, 64'h0);
        chk("rst_pulses_a", {62'b0, wp_a, fe_a}, 64'h0);
        chk("rst_wa_a", {57'b0, wa_a}, 64'h0);
        rst_n = 1'b1;
        tick(4);

        // A: write 0xA5 to reg 2
        do_frame(0, 16, 32'h82A5, miso, oe, wph, feh);
        chk("wr2_oe", {63'b0, oe}, 64'h1);
        chk("wr2_pulse", {58'b0, wph}, 64'h08);
        chk("wr2_err", {58'b0, feh}, 64'h0);
        chk("wr2_regs", regs_a, 64'h0000_0000_00A5_0000);
        chk("wr2_addr", {57'b0, wa_a}, 64'd2);

        // A: write 0xC3 to reg 5, then read it back
        do_frame(0, 16, 32'h85C3, miso, oe, wph, feh);
        chk("wr5_pulse", {58'b0, wph}, 64'h08);
        chk("wr5_regs", regs_a, 64'h0000_C300_00A5_0000);
        do_frame(0, 16, 32'h0500, miso, oe, wph, feh);
        chk("rd5_cipo", {48'b0, miso[15:0]}, 64'h00C3);
        chk("rd5_pulse", {58'b0, wph}, 64'h0);
        chk("rd5_err", {58'b0, feh}, 64'h0);
        chk("rd5_regs", regs_a, 64'h0000_C300_00A5_0000);
        chk("rd5_idle", {62'b0, cipo_a, oe_a}, 64'h0);

        // A: out-of-range address, write then read
        do_frame(0, 16, 32'h8977, miso, oe, wph, feh);
        chk("wr9_pulse", {58'b0, wph}, 64'h0);
        chk("wr9_err", {58'b0, feh}, 64'h0);
        chk("wr9_regs", regs_a, 64'h0000_C300_00A5_0000);
        chk("wr9_addr", {57'b0, wa_a}, 64'd5);
        do_frame(0, 16, 32'h0900, miso, oe, wph, feh);
        chk("rd9_cipo", {48'b0, miso[15:0]}, 64'h0);

        // A: short (10-bit) and long (17-bit) frames to reg 1
        do_frame(0, 10, 32'h207, miso, oe, wph, feh);
        chk("short_err", {58'b0, feh}, 64'h08);
        chk("short_pulse", {58'b0, wph}, 64'h0);
        chk("short_regs", regs_a, 64'h0000_C300_00A5_0000);
        do_frame(0, 17, 32'h103FF, miso, oe, wph, feh);
        chk("long_err", {58'b0, feh}, 64'h08);
        chk("long_pulse", {58'b0, wph}, 64'h0);
        chk("long_regs", regs_a, 64'h0000_C300_00A5_0000);

        // A: reset after 12 bits of a write, then a clean write of 0x3C to reg 0
        cs_low(0);
        spi_bits(0, 12, 32'h803, miso, oe);
        rst_n = 1'b0;
        tick(2);
        chk("mid_rst_regs_a", regs_a, 64'h0);
        chk("mid_rst_wa_a", {57'b0, wa_a}, 64'h0);
        chk("mid_rst_oe_a", {63'b0, oe_a}, 64'h0);
        rst_n = 1'b1;
        tick(2);
        cs_high_watch(0, wph, feh);
        chk("mid_rst_pulse_a", {58'b0, wph}, 64'h0);
        chk("mid_rst_regs_a2", regs_a, 64'h0);
        do_frame(0, 16, 32'h803C, miso, oe, wph, feh);
        chk("wr0_pulse_a", {58'b0, wph}, 64'h08);
        chk("wr0_regs_a", regs_a, 64'h0000_0000_0000_003C);

        // B: 20-bit frames
        do_frame(1, 20, 32'hABEEF, miso, oe, wph, feh);
        chk("b_wr2_pulse", {58'b0, wph}, 64'h08);
        chk("b_wr2_err", {58'b0, feh}, 64'h0);
        chk("b_wr2_regs", regs_b, 64'h5A5A_BEEF_5A5A_5A5A);
        chk("b_wr2_addr", {61'b0, wa_b}, 64'd2);
        do_frame(1, 20, 32'h20000, miso, oe, wph, feh);
        chk("b_rd2_cipo", {44'b0, miso[19:0]}, 64'h0BEEF);
        chk("b_rd2_pulse", {58'b0, wph}, 64'h0);
        do_frame(1, 20, 32'hD1234, miso, oe, wph, feh);
        chk("b_wr5_pulse", {58'b0, wph}, 64'h0);
        chk("b_wr5_err", {58'b0, feh}, 64'h0);
        chk("b_wr5_regs", regs_b, 64'h5A5A_BEEF_5A5A_5A5A);

        cs_low(1);
        spi_bits(1, 12, 32'h800, miso, oe);
        rst_n = 1'b0;
        tick(2);
        chk("b_mid_rst_regs", regs_b, 64'h5A5A_5A5A_5A5A_5A5A);
        rst_n = 1'b1;
        tick(2);
        cs_high_watch(1, wph, feh);
        chk("b_mid_rst_pulse", {58'b0, wph}, 64'h0);
        do_frame(1, 20, 32'h8003C, miso, oe, wph, feh);
        chk("b_wr0_pulse", {58'b0, wph}, 64'h08);
        chk("b_wr0_regs", regs_b, 64'h5A5A_5A5A_5A5A_003C);
        chk("b_wr0_addr", {61'b0, wa_b}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
